// File: rtl/frogger_pkg.sv
// Shared playfield constants, car coordinate types and lane tables for the frogger game.
package frogger_pkg;

  localparam int GRID_COLS  = 20;
  localparam int GRID_ROWS  = 15;
  localparam int CAR_SLOTS  = 16;
  localparam int LANE_COUNT = 8;

  typedef logic [4:0] car_x_t;
  typedef logic [3:0] car_y_t;
  typedef logic [3:0] div_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_CHECK  = 2'd2
  } sched_state_t;

  localparam car_y_t   LANE_ROW    [LANE_COUNT] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
  localparam div_cnt_t BASE_PERIOD [LANE_COUNT] = '{4'd8, 4'd6, 4'd5, 4'd4, 4'd8, 4'd6, 4'd5, 4'd4};

  // The two cars of a lane start half a playfield apart.
  function automatic car_x_t init_x(input int car);
    if (car % 2 == 0) return car_x_t'(car);
    return car_x_t'((car + 9) % GRID_COLS);
  endfunction

  function automatic div_cnt_t lane_period(input div_cnt_t base, input logic [1:0] lvl);
    return (base > {2'b00, lvl}) ? (base - {2'b00, lvl}) : 4'd1;
  endfunction

endpackage

// File: rtl/traffic_scheduler_if.sv
// Control/status bundle between the game controller and the traffic scheduler.
interface traffic_scheduler_if;
  import frogger_pkg::*;

  logic                     frame_tick;
  logic                     run;
  logic                     restart;
  logic [1:0]               level;
  car_x_t                   frog_col;
  car_y_t                   frog_row;
  logic [CAR_SLOTS*5-1:0]   car_x;
  logic [CAR_SLOTS*4-1:0]   car_y;
  logic                     busy;
  logic                     hit;
  logic                     overrun;

  modport master (
    output frame_tick, run, restart, level, frog_col, frog_row,
    input  car_x, car_y, busy, hit, overrun
  );

  modport slave (
    input  frame_tick, run, restart, level, frog_col, frog_row,
    output car_x, car_y, busy, hit, overrun
  );

endinterface

// File: rtl/lane_stepper.sv
// Combinational one-column step of a car x position, wrapping at the playfield edges.
module lane_stepper
  import frogger_pkg::*;
#(
  parameter int COLS = 20
) (
  input  car_x_t x,
  input  logic   dir_left,
  output car_x_t x_next
);

  localparam car_x_t X_MAX = car_x_t'(COLS - 1);

  always_comb begin
    if (dir_left) x_next = (x == 5'd0) ? X_MAX : (x - 5'd1);
    else          x_next = (x == X_MAX) ? 5'd0 : (x + 5'd1);
  end

endmodule

// File: rtl/traffic_scheduler.sv
// Per-frame car sequencer: on each accepted vblank tick walks the lanes one per cycle,
// steps cars whose divider expires, then checks the frog cell for a collision.
module traffic_scheduler #(
  parameter int NUM_CARS  = 16,
  parameter int NUM_LANES = 8,
  parameter int GRID_COLS = 20
) (
  input logic               clk,
  input logic               rst_n,
  traffic_scheduler_if.slave bus
);
  import frogger_pkg::*;

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);

  sched_state_t  state_q, state_d;
  logic [LW-1:0] lane_q;
  logic [1:0]    level_q;
  div_cnt_t      cnt_q [NUM_LANES];
  car_x_t        x_q   [NUM_CARS];
  logic          hit_q, overrun_q;

  logic     latch_en, upd_en, chk_en, busy_c;
  logic     step_lane, frog_hit;
  div_cnt_t period;
  car_x_t   x_a_next, x_b_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           state_q <= ST_IDLE;
    else if (bus.restart) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.frame_tick && bus.run) state_d = ST_UPDATE;
      ST_UPDATE: if (lane_q == LAST_LANE)       state_d = ST_CHECK;
      ST_CHECK:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_en = 1'b0;
    upd_en   = 1'b0;
    chk_en   = 1'b0;
    busy_c   = 1'b1;
    unique case (state_q)
      ST_IDLE:   begin latch_en = bus.frame_tick & bus.run; busy_c = 1'b0; end
      ST_UPDATE: upd_en = 1'b1;
      ST_CHECK:  chk_en = 1'b1;
      default:   busy_c = 1'b0;
    endcase
  end

  // Both cars of the selected lane share one pair of steppers; odd lanes drive left.
  lane_stepper #(.COLS(GRID_COLS)) u_step_a (.x(x_q[{lane_q, 1'b0}]), .dir_left(lane_q[0]), .x_next(x_a_next));
  lane_stepper #(.COLS(GRID_COLS)) u_step_b (.x(x_q[{lane_q, 1'b1}]), .dir_left(lane_q[0]), .x_next(x_b_next));

  assign period    = lane_period(BASE_PERIOD[lane_q], level_q);
  assign step_lane = (cnt_q[lane_q] == (period - 4'd1));

  always_comb begin
    frog_hit = 1'b0;
    for (int i = 0; i < NUM_CARS; i++)
      if ((x_q[i] == bus.frog_col) && (LANE_ROW[i/2] == bus.frog_row)) frog_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q    <= '0;
      level_q   <= '0;
      hit_q     <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
      for (int i = 0; i < NUM_CARS; i++)  x_q[i]   <= init_x(i);
    end else if (bus.restart) begin
      lane_q    <= '0;
      level_q   <= '0;
      hit_q     <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
      for (int i = 0; i < NUM_CARS; i++)  x_q[i]   <= init_x(i);
    end else begin
      hit_q     <= chk_en & frog_hit;
      overrun_q <= bus.frame_tick & busy_c;
      if (latch_en) begin
        level_q <= bus.level;
        lane_q  <= '0;
      end
      if (upd_en) begin
        lane_q <= lane_q + LW'(1);
        if (step_lane) begin
          cnt_q[lane_q]        <= '0;
          x_q[{lane_q, 1'b0}]  <= x_a_next;
          x_q[{lane_q, 1'b1}]  <= x_b_next;
        end else begin
          cnt_q[lane_q] <= cnt_q[lane_q] + 4'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
    assign bus.car_x[5*i +: 5] = x_q[i];
    assign bus.car_y[4*i +: 4] = LANE_ROW[i/2];
  end

  assign bus.busy    = busy_c;
  assign bus.hit     = hit_q;
  assign bus.overrun = overrun_q;

endmodule

// File: doc/traffic_scheduler.md
# traffic_scheduler

- Sequences the 16 car sprites consumed by `vga_display`: once per video frame it advances every lane by its own speed divider and wraps cars at the playfield edges.
- After each update pass it checks the frog cell against all cars and reports a hit to the game controller.
- It sits between the frame-timing source (vblank tick) and the VGA renderer; its position outputs connect directly to the renderer's `carN_x` and `carN_y` inputs.

## Interface
Parameters:
- `NUM_CARS`, 16: car slots, two per lane.
- `NUM_LANES`, 8: lanes.
- `GRID_COLS`, 20: playfield columns, 640/32.

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse at start of vblank.
- `run`  in  1  1 = traffic moves; 0 = frozen.
- `restart`  in  1  one-cycle pulse; reload initial positions and dividers.
- `level`  in  2  speed level 0..3, sampled on accepted `frame_tick`.
- `frog_col`  in  5  frog grid column.
- `frog_row`  in  4  frog grid row.
- `car_x`  out  80  packed; car i at [5i+4:5i].
- `car_y`  out  64  packed; car i at [4i+3:4i].
- `busy`  out  1  update pass in progress.
- `hit`  out  1  one-cycle pulse; frog shares a cell with a car.
- `overrun`  out  1  one-cycle pulse; `frame_tick` arrived while busy.

## Operation
Lanes and cars:
- Lane l holds cars 2l and 2l+1.
- Row is fixed: `car_y[i] = LANE_ROW[i/2]`.
- Direction: even lanes move right (+1), odd lanes move left (−1).

Initial positions:
- `INIT_X[2l] = 2l`.
- `INIT_X[2l+1] = (2l+10) mod 20`.

Divider per lane:
- 4-bit frame counter `cnt[l]`.
- Period `P[l] = max(BASE_PERIOD[l] − level, 1)`, using the level latched at the tick.

FSM:
- IDLE: a `frame_tick` with `run`=1 latches `level`, sets lane index = 0, goes to UPDATE. A tick with `run`=0 is ignored (no counting).
- UPDATE: one lane per cycle, lane index 0..7.
  - If `cnt[l] == P[l]−1`: `cnt[l]` ← 0 and both cars of the lane step one column.
  - Otherwise `cnt[l]` ← `cnt[l]+1`.
  - After lane 7, go to CHECK.
- CHECK: one cycle. Compare (`frog_col`,`frog_row`) to all 16 (x,y) pairs in parallel; any match registers `hit`=1 for the next cycle. Then IDLE.

Wrap rules:
- Right-moving car at x=19 → 0.
- Left-moving car at x=0 → 19.
- x never leaves 0..19.

Priority and boundary cases:
- `restart` has highest priority, in any state. Next cycle: positions = INIT, all `cnt` = 0, state = IDLE, `hit`/`overrun` = 0. A `frame_tick` in the same cycle is dropped.
- `frame_tick` while in UPDATE/CHECK: the pass is not restarted and `overrun` pulses next cycle.
- `run` deasserted mid-pass: the pass completes; only new ticks are blocked.
- `level` changes mid-pass: no effect until the next accepted tick.

Reset values (`rst_n`=0, immediate):
- State IDLE, `busy`=0, `hit`=0, `overrun`=0.
- All `cnt` = 0.
- `car_x` = INIT_X; `car_y` = LANE_ROW mapping.

## Timing
Accepted tick in cycle T:
- `busy`=1 from T+1 through T+9.
- Lane l positions change at the clock edge ending cycle T+1+l and are visible at T+2+l.
- CHECK runs in cycle T+9; `hit` is valid at T+10 for exactly one cycle; `busy`=0 at T+10.
- A tick is next accepted at T+10.
- The 9-cycle pass is far shorter than vblank (45 lines), so the renderer never sees a torn frame.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
Shared package `frogger_pkg`:
- `GRID_COLS`=20, `GRID_ROWS`=15.
- `LANE_ROW` = {2,3,4,5,8,9,10,11}.
- `BASE_PERIOD` = {8,6,5,4,8,6,5,4}.
- `INIT_X` function.
- Car x/y typedefs (5/4 bits).

Sub-module `lane_stepper`:
- Purely combinational.
- Inputs: x, direction. Output: next x with wrap.
- Reused per lane in the UPDATE mux.

## Test plan
- Reset release, no ticks → car0=(0,2), car1=(10,2), car15=(4,11); `busy`=0.
- `run`=1, `level`=0, 8 ticks spaced 1000 cycles → car0 x=1, car1 x=11. After tick 1: `busy` high 9 cycles, `hit`=0.
- `level`=3, 5 ticks → lane7 period = max(4−3,1) = 1: car15 x 4→3→2→1→0→19 (wrap), car14 x 14→9.
- Frog at (1,2), `level`=0, 8 ticks → `hit` pulses exactly once, at T+10 of the 8th tick.
- Second tick at T+3 of a pass → `overrun` at T+4; car positions match the single-tick reference model.
- `restart` at T+4 of a pass → at T+5 positions = INIT, `busy`=0. Async `rst_n` pulse mid-pass → same state immediately.
